// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative multiply/divide unit.
//   - aluControl codes for the M-extension ops (0xA..0x11)
//   - FSM state encoding
//   - small op-classification helpers
package muldiv_pkg;

    localparam logic [4:0] ALU_MUL    = 5'h0A;
    localparam logic [4:0] ALU_MULH   = 5'h0B;
    localparam logic [4:0] ALU_MULHSU = 5'h0C;
    localparam logic [4:0] ALU_MULHU  = 5'h0D;
    localparam logic [4:0] ALU_DIV    = 5'h0E;
    localparam logic [4:0] ALU_DIVU   = 5'h0F;
    localparam logic [4:0] ALU_REM    = 5'h10;
    localparam logic [4:0] ALU_REMU   = 5'h11;

    typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_e;

    function automatic logic isLegalOp(input logic [4:0] op);
        return (op >= ALU_MUL) && (op <= ALU_REMU);
    endfunction

    function automatic logic isMulOp(input logic [4:0] op);
        return (op >= ALU_MUL) && (op <= ALU_MULHU);
    endfunction

    // rs1 is interpreted as signed (MUL low half is sign-agnostic, so it is
    // handled as unsigned).
    function automatic logic isSignedOp(input logic [4:0] op);
        return (op == ALU_MULH) || (op == ALU_MULHSU) ||
               (op == ALU_DIV)  || (op == ALU_REM);
    endfunction

endpackage

// File: rtl/muldiv_operand_prep.sv
// muldiv_operand_prep: combinational operand conditioning.
//   op_i, a_i, b_i   : captured op and operands
//   absA_o, absB_o   : magnitudes (sign removed only where the op is signed)
//   negRes_o         : product/quotient must be negated at the end
//   negRem_o         : remainder must be negated (takes dividend's sign)
//   div0_o, ovf_o    : divide-by-zero / signed-overflow detect (div ops only)
//   legal_o, isMul_o : op classification
module muldiv_operand_prep
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [4:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] absA_o,
    output logic [XLEN-1:0] absB_o,
    output logic            negRes_o,
    output logic            negRem_o,
    output logic            div0_o,
    output logic            ovf_o,
    output logic            legal_o,
    output logic            isMul_o
);
    logic sA, sB, signedB, isDiv;

    // rs2 is signed for MULH/DIV/REM; MULHSU keeps rs2 unsigned.
    assign signedB  = (op_i == ALU_MULH) || (op_i == ALU_DIV) || (op_i == ALU_REM);
    assign sA       = isSignedOp(op_i) & a_i[XLEN-1];
    assign sB       = signedB & b_i[XLEN-1];
    assign absA_o   = sA ? -a_i : a_i;
    assign absB_o   = sB ? -b_i : b_i;
    assign negRes_o = sA ^ sB;
    assign negRem_o = sA;
    assign legal_o  = isLegalOp(op_i);
    assign isMul_o  = isMulOp(op_i);
    assign isDiv    = legal_o & ~isMul_o;
    assign div0_o   = isDiv && (b_i == '0);
    assign ovf_o    = ((op_i == ALU_DIV) || (op_i == ALU_REM)) &&
                      (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (&b_i);
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 RV32M/RV64M multiply/divide unit.
//   clk, rstN              : clock, async active-low reset
//   inValid/inReady        : request handshake (ready only in IDLE)
//   aluControl, srcA, srcB : op code and operands, captured on accept
//   flush                  : abort any in-flight op
//   outValid/outReady      : result handshake, result held until taken
//   result, opErr          : result word, illegal-op flag
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic            clk,
    input  logic            rstN,
    input  logic            inValid,
    output logic            inReady,
    input  logic [4:0]      aluControl,
    input  logic [XLEN-1:0] srcA,
    input  logic [XLEN-1:0] srcB,
    input  logic            flush,
    output logic            outValid,
    input  logic            outReady,
    output logic [XLEN-1:0] result,
    output logic            opErr
);
    localparam int CW = $clog2(XLEN) + 1;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     a_q, a_d, b_q, b_d, opnd_q, opnd_d, result_q, result_d;
    logic [4:0]          op_q, op_d;
    logic                negRes_q, negRes_d, negRem_q, negRem_d;
    logic                div0_q, div0_d, ovf_q, ovf_d, opErr_q, opErr_d;

    logic [XLEN-1:0]     absA, absB;
    logic                pNegRes, pNegRem, pDiv0, pOvf, pLegal, pIsMul;

    muldiv_operand_prep #(.XLEN(XLEN)) u_prep (
        .op_i(op_q), .a_i(a_q), .b_i(b_q),
        .absA_o(absA), .absB_o(absB), .negRes_o(pNegRes), .negRem_o(pNegRem),
        .div0_o(pDiv0), .ovf_o(pOvf), .legal_o(pLegal), .isMul_o(pIsMul)
    );

    // Multiply step: acc = {partial hi, remaining multiplier bits}; add the
    // multiplicand into the high half when the multiplier LSB is set, then
    // shift right keeping the carry.
    logic [XLEN:0]       mulSum;
    logic [2*XLEN-1:0]   mulNext;
    assign mulSum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mulNext = {mulSum, acc_q[XLEN-1:1]};

    // Restoring divide step: acc = {remainder, dividend/quotient}. The shifted
    // remainder needs XLEN+1 bits before the trial subtract.
    logic [XLEN:0]       divTrial;
    logic [2*XLEN-1:0]   divNext;
    assign divTrial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opnd_q};
    assign divNext  = divTrial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                     : {divTrial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

    // Final result selection with sign fix-up and div0/overflow overrides.
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     quot, rem, fixRes, earlyRes;
    logic                isRem;
    assign isRem = (op_q == ALU_REM) || (op_q == ALU_REMU);
    assign prod  = negRes_q ? -acc_q : acc_q;
    assign quot  = div0_q ? '1 : ovf_q ? a_q : (negRes_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0]);
    assign rem   = div0_q ? a_q : ovf_q ? '0 : (negRem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN]);

    always_comb begin
        fixRes = rem;
        case (op_q)
            ALU_MUL:                        fixRes = prod[XLEN-1:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU: fixRes = prod[2*XLEN-1:XLEN];
            ALU_DIV, ALU_DIVU:              fixRes = quot;
            default:                        fixRes = rem;
        endcase
    end

    assign earlyRes = pDiv0 ? (isRem ? a_q : '1) : (isRem ? '0 : a_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        opnd_d   = opnd_q;
        negRes_d = negRes_q;
        negRem_d = negRem_q;
        div0_d   = div0_q;
        ovf_d    = ovf_q;
        result_d = result_q;
        opErr_d  = opErr_q;
        // flush beats everything, including a same-cycle accept
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (inValid) begin
                    a_d     = srcA;
                    b_d     = srcB;
                    op_d    = aluControl;
                    state_d = PREP;
                end
                PREP: begin
                    negRes_d = pNegRes;
                    negRem_d = pNegRem;
                    div0_d   = pDiv0;
                    ovf_d    = pOvf;
                    opnd_d   = pIsMul ? absA : absB;
                    acc_d    = {{XLEN{1'b0}}, (pIsMul ? absB : absA)};
                    cnt_d    = CW'(XLEN - 1);
                    if (!pLegal) begin
                        state_d  = DONE;
                        result_d = '0;
                        opErr_d  = 1'b1;
                    end else if (EARLY_OUT && (pDiv0 || pOvf)) begin
                        state_d  = DONE;
                        result_d = earlyRes;
                        opErr_d  = 1'b0;
                    end else begin
                        state_d  = CALC;
                    end
                end
                CALC: begin
                    acc_d = isMulOp(op_q) ? mulNext : divNext;
                    if (cnt_q == '0) state_d = FIX;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                FIX: begin
                    result_d = fixRes;
                    opErr_d  = 1'b0;
                    state_d  = DONE;
                end
                DONE: if (outReady) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            opnd_q   <= '0;
            negRes_q <= 1'b0;
            negRem_q <= 1'b0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
            opErr_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            opnd_q   <= opnd_d;
            negRes_q <= negRes_d;
            negRem_q <= negRem_d;
            div0_q   <= div0_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
            opErr_q  <= opErr_d;
        end
    end

    assign inReady  = (state_q == IDLE);
    assign outValid = (state_q == DONE);
    assign result   = result_q;
    assign opErr    = opErr_q;
endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
    localparam int XLEN = 32;
    localparam int LAT  = XLEN + 3;

    logic        clk = 1'b0, rstN = 1'b0, inValid = 1'b0, flush = 1'b0, outReady = 1'b0;
    logic [4:0]  aluControl = '0;
    logic [31:0] srcA = '0, srcB = '0;
    logic        inReady, outValid, opErr;
    logic [31:0] result;

    muldiv_unit #(.XLEN(XLEN), .EARLY_OUT(1'b1)) dut (
        .clk(clk), .rstN(rstN), .inValid(inValid), .inReady(inReady),
        .aluControl(aluControl), .srcA(srcA), .srcB(srcB), .flush(flush),
        .outValid(outValid), .outReady(outReady), .result(result), .opErr(opErr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sb[$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Issue one op, check latency/result/opErr from the scoreboard, optionally
    // hold outReady low for 'hold' cycles, then complete the handshake.
    task automatic do_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] er, input logic ee,
                         input int el, input int hold);
        exp_t e;
        int   lat;
        @(negedge clk);
        chk({tag, "_inReady"}, 64'(inReady), 64'd1);
        aluControl = op; srcA = a; srcB = b; inValid = 1'b1;
        e.res = er; e.err = ee; e.lat = el;
        @(posedge clk);
        sb.push_back(e);
        #1;
        inValid = 1'b0; srcA = $urandom; srcB = $urandom; aluControl = 5'(op + 5'd1);
        lat = 1;
        while (lat < 100) begin
            @(negedge clk);
            if (outValid) break;
            @(posedge clk);
            lat++;
        end
        e = sb.pop_front();
        chk({tag, "_lat"}, 64'(lat), 64'(e.lat));
        chk({tag, "_res"}, 64'(result), 64'(e.res));
        chk({tag, "_err"}, 64'(opErr), 64'(e.err));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_v"}, 64'(outValid), 64'd1);
            chk({tag, "_hold_r"}, 64'(result), 64'(e.res));
            chk({tag, "_hold_rdy"}, 64'(inReady), 64'd0);
        end
        outReady = 1'b1;
        @(posedge clk);
        #1 outReady = 1'b0;
        @(negedge clk);
        chk({tag, "_post_v"}, 64'(outValid), 64'd0);
        chk({tag, "_post_rdy"}, 64'(inReady), 64'd1);
    endtask

    initial begin
        int seen;
        // reset state
        #12;
        chk("rst_valid", 64'(outValid), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_opErr", 64'(opErr), 64'd0);
        @(negedge clk); rstN = 1'b1;
        @(negedge clk);
        chk("rst_inReady", 64'(inReady), 64'd1);

        do_op("MUL",    5'h0A, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, LAT, 0);
        do_op("MULH",   5'h0B, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, LAT, 0);
        do_op("MULHU",  5'h0D, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, LAT, 0);
        do_op("MULHSU", 5'h0C, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1'b0, LAT, 0);
        do_op("DIV",    5'h0E, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, LAT, 0);
        do_op("REM",    5'h10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, LAT, 0);
        do_op("DIVU",   5'h0F, 32'd7,        32'd2,        32'd3,        1'b0, LAT, 0);
        do_op("REMU",   5'h11, 32'd7,        32'd2,        32'd1,        1'b0, LAT, 0);
        do_op("DIV0",   5'h0E, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b0, 2,   0);
        do_op("REM0",   5'h10, 32'd5,        32'd0,        32'd5,        1'b0, 2,   0);
        do_op("DIVOVF", 5'h0E, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 2,   0);
        do_op("REMOVF", 5'h10, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b0, 2,   0);
        do_op("BP",     5'h0F, 32'd100,      32'd7,        32'd14,       1'b0, LAT, 10);
        do_op("MULneg", 5'h0A, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        1'b0, LAT, 0);

        // flush in the 10th CALC cycle: no result must ever appear
        @(negedge clk);
        aluControl = 5'h0A; srcA = 32'd3; srcB = 32'd4; inValid = 1'b1;
        @(posedge clk); #1 inValid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_inReady", 64'(inReady), 64'd1);
        chk("flush_valid", 64'(outValid), 64'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (outValid) seen++;
        end
        chk("flush_noout", 64'(seen), 64'd0);

        // flush and accept in the same cycle: request dropped
        @(negedge clk);
        aluControl = 5'h0F; srcA = 32'd9; srcB = 32'd3; inValid = 1'b1; flush = 1'b1;
        @(posedge clk); #1 inValid = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("flushacc_inReady", 64'(inReady), 64'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (outValid) seen++;
        end
        chk("flushacc_noout", 64'(seen), 64'd0);

        do_op("ILLEGAL", 5'h03, 32'd12, 32'd5, 32'd0, 1'b1, 2, 0);
        do_op("DIVUpost", 5'h0F, 32'd1000, 32'd10, 32'd100, 1'b0, LAT, 0);

        // async reset mid-CALC
        @(negedge clk);
        aluControl = 5'h0E; srcA = 32'd50; srcB = 32'd5; inValid = 1'b1;
        @(posedge clk); #1 inValid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk); rstN = 1'b0;
        #1;
        chk("midrst_valid", 64'(outValid), 64'd0);
        chk("midrst_result", 64'(result), 64'd0);
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        chk("midrst_inReady", 64'(inReady), 64'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (outValid) seen++;
        end
        chk("midrst_noout", 64'(seen), 64'd0);

        do_op("REMUpost", 5'h11, 32'd1000, 32'd7, 32'd6, 1'b0, LAT, 0);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
